// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the 256x36 single-port SRAM arbiter.
// Related build option: SRAM_ARB_ZERO_INIT_EN (zero-fill sweep after reset).
package sram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 36;

  // Which requester owns the SRAM port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WRITE = 2'd1,
    GNT_READ  = 2'd2
  } grant_e;

  // Zero-fill sequencer state (only used when SRAM_ARB_ZERO_INIT_EN is defined).
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

endpackage : sram_arb_pkg

// File: rtl/sram_arb_resp_fifo.sv
// Small response FIFO for SRAM read data.
// Valid/ready on both sides, asynchronous active-low reset, fall-through head.
// The occupancy count is exported so the arbiter can budget read credits.
module sram_arb_resp_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = sram_arb_pkg::DATA_W,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_fire;
  logic             pop_fire;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ready_o = (count_q != CNT_W'(DEPTH)) | pop_ready_i;
  assign pop_valid_o  = (count_q != '0);
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = pop_valid_o & pop_ready_i;
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  // Storage: written only on an accepted push; the head slot is never
  // overwritten while it is still waiting, so pop_data_o stays stable.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_fire) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_fire && !pop_fire) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_fire && pop_fire) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule : sram_arb_resp_fifo

// File: rtl/sram_1rw_arbiter_256x36.sv
// Round-robin arbiter/controller for one external 256x36 1RW SRAM macro.
// A write requester and a read requester share the single port; read data
// (one cycle after the enable) lands in a small response FIFO, and reads are
// only granted while FIFO occupancy plus the in-flight read leaves room.
// Build option SRAM_ARB_ZERO_INIT_EN: after reset, sweep zeros into all
// 256 words before accepting any request.
module sram_1rw_arbiter_256x36
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = sram_arb_pkg::ADDR_W,
  parameter int DATA_W     = sram_arb_pkg::DATA_W,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,       // asynchronous, active-low
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  // While reset is held the handshakes and the SRAM enable must read as 0,
  // even though grants are otherwise combinational on the request valids.
  logic live;
  assign live = reset;

  logic              init_ok;      // requests may be served
  logic              init_active;  // zero-fill sweep owns the SRAM port
  logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_ARB_ZERO_INIT_EN
  init_state_e       state_q;
  init_state_e       state_d;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [ADDR_W-1:0] init_cnt_d;

  // Sweep state register; reset restarts the fill at address 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state: one word per cycle, leave INIT once the last address is written.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + ADDR_W'(1);
      if (init_cnt_q == '1) begin
        state_d = RUN;
      end
    end
  end

  assign init_ok     = (state_q == RUN);
  assign init_active = live & (state_q == INIT);
  assign init_addr   = init_cnt_q;
`else
  assign init_ok     = 1'b1;
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  assign init_done = init_ok;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push_ready;
  logic             inflight_q;
  logic             rr_read_q;     // 1: read side wins the next tie
  logic             credit_ok;
  logic             read_elig;
  logic             write_elig;
  grant_e           grant;

  // Every read accepted now must have a FIFO slot waiting for it later.
  assign credit_ok  = (int'(fifo_count) + int'(inflight_q)) < RESP_DEPTH;
  assign read_elig  = live & init_ok & r_valid & credit_ok;
  assign write_elig = live & init_ok & w_valid;

  // Single grant per cycle; ties resolved by the round-robin pointer.
  always_comb begin
    grant = GNT_NONE;
    if (read_elig && write_elig) begin
      grant = rr_read_q ? GNT_READ : GNT_WRITE;
    end else if (read_elig) begin
      grant = GNT_READ;
    end else if (write_elig) begin
      grant = GNT_WRITE;
    end
  end

  assign w_ready = (grant == GNT_WRITE);
  assign r_ready = (grant == GNT_READ);

  // ---------------------------------------------------------------------
  // SRAM port drive
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_wmode_q;
  logic              mem_wmode_d;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_en_d;

  // Idle cycles keep the last address/mode/data so the macro pins do not toggle.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wmode_d = mem_wmode_q;
    mem_wdata_d = mem_wdata_q;
    if (init_active) begin
      mem_en_d    = 1'b1;
      mem_wmode_d = 1'b1;
      mem_addr_d  = init_addr;
      mem_wdata_d = '0;
    end else begin
      case (grant)
        GNT_WRITE: begin
          mem_en_d    = 1'b1;
          mem_wmode_d = 1'b1;
          mem_addr_d  = w_addr;
          mem_wdata_d = w_data;
        end
        GNT_READ: begin
          mem_en_d    = 1'b1;
          mem_wmode_d = 1'b0;
          mem_addr_d  = r_addr;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_en    = mem_en_d;
  assign mem_addr  = mem_addr_d;
  assign mem_wmode = mem_wmode_d;
  assign mem_wdata = mem_wdata_d;

  // Round-robin pointer, in-flight read flag and held SRAM pin values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_read_q   <= 1'b1;
      inflight_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmode_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      if (grant == GNT_READ) begin
        rr_read_q <= 1'b0;
      end else if (grant == GNT_WRITE) begin
        rr_read_q <= 1'b1;
      end
      inflight_q  <= (grant == GNT_READ);
      mem_addr_q  <= mem_addr_d;
      mem_wmode_q <= mem_wmode_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // Response buffering
  // ---------------------------------------------------------------------
  // mem_rdata only means something the cycle after a read enable, so the
  // push is qualified by inflight_q. The credit rule keeps push_ready high
  // whenever inflight_q is set; qualifying with it just keeps the FIFO safe.
  logic fifo_push;
  assign fifo_push = inflight_q & fifo_push_ready;

  sram_arb_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk_i        (clock),
    .rst_ni       (reset),
    .push_valid_i (fifo_push),
    .push_ready_o (fifo_push_ready),
    .push_data_i  (mem_rdata),
    .pop_valid_o  (resp_valid),
    .pop_ready_i  (resp_ready),
    .pop_data_o   (resp_data),
    .count_o      (fifo_count)
  );

endmodule : sram_1rw_arbiter_256x36
